// File: rtl/fm_discrim_dec_pkg.sv
// Shared definitions for the baseband demodulator family: mode encodings,
// accumulator sizing and a generic saturate-to-width helper.
package fm_discrim_dec_pkg;

   typedef enum logic {
      MODE_FM = 1'b0,
      MODE_AM = 1'b1
   } demod_mode_e;

   localparam int SAT_MAX_W = 128;

   function automatic int calc_acc_w(input int in_w, input int dec_w);
      return 2 * in_w + 1 + dec_w;
   endfunction

   // Clamp a wide signed value into the signed range of 'width' bits.
   function automatic logic signed [SAT_MAX_W-1:0] sat_to_width(
      input logic signed [SAT_MAX_W-1:0] val,
      input int                          width
   );
      logic signed [SAT_MAX_W-1:0] one;
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      one = 1;
      hi  = (one <<< (width - 1)) - one;
      lo  = ~hi;
      if (val > hi) begin
         return hi;
      end
      if (val < lo) begin
         return lo;
      end
      return val;
   endfunction

endpackage

// File: rtl/fm_discrim_dec_sat_shift.sv
// Arithmetic right shift (floor) of the accumulator followed by saturation
// to the output width, with a flag raised whenever clipping occurred.
module fm_discrim_dec_sat_shift
   import fm_discrim_dec_pkg::*;
#(
   parameter int ACC_W = 45,
   parameter int OUT_W = 16
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic [5:0]              shift,
   output logic signed [OUT_W-1:0] sat_out,
   output logic                    ovf
);

   logic signed [ACC_W-1:0]     shifted;
   logic signed [SAT_MAX_W-1:0] wide;
   logic signed [SAT_MAX_W-1:0] clipped;

   always_comb begin
      shifted = acc >>> shift;
      wide    = {{(SAT_MAX_W-ACC_W){shifted[ACC_W-1]}}, shifted};
      clipped = sat_to_width(wide, OUT_W);
      sat_out = clipped[OUT_W-1:0];
      ovf     = (clipped != wide);
   end

endmodule

// File: rtl/fm_discrim_dec.sv
// FM cross-product discriminator / AM envelope detector with run-time
// integrate-and-dump decimation, scaling and saturation. Five register stages.
module fm_discrim_dec
   import fm_discrim_dec_pkg::*;
#(
   parameter int IN_W  = 18,
   parameter int OUT_W = 16,
   parameter int DEC_W = 8
) (
   input  logic                    clk_data,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  in_i,
   input  logic signed [IN_W-1:0]  in_q,
   input  logic                    mode,
   input  logic [DEC_W-1:0]        dec_ratio,
   input  logic [5:0]              out_shift,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   output logic                    sat_flag
);

   localparam int ACC_W = calc_acc_w(IN_W, DEC_W);
   localparam int P_W   = 2 * IN_W;
   localparam int D_W   = 2 * IN_W + 1;
   localparam logic signed [IN_W-1:0] IN_MAX = {1'b0, {(IN_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] IN_MIN = {1'b1, {(IN_W-1){1'b0}}};
   localparam logic [DEC_W-1:0]       ONE    = DEC_W'(1);

   function automatic logic signed [IN_W-1:0] sat_abs(input logic signed [IN_W-1:0] x);
      if (x == IN_MIN) begin
         return IN_MAX;
      end
      return (x < 0) ? -x : x;
   endfunction

   logic [DEC_W-1:0]       cnt, ratio_l, eff_in, cur_ratio;
   demod_mode_e            mode_l, cur_mode;
   logic                   is_first, is_last;
   logic signed [IN_W-1:0] hist_i, hist_q;
   logic                   primed;

   logic                   s1_v, s1_primed, s1_first, s1_last;
   logic signed [IN_W-1:0] s1_i, s1_q, s1_pi, s1_pq;
   demod_mode_e            s1_mode;

   logic signed [P_W-1:0]  prod_a, prod_b, s2_p1, s2_p2;
   logic signed [IN_W-1:0] s2_a, s2_b;
   logic                   s2_v, s2_first, s2_last;
   demod_mode_e            s2_mode;

   logic signed [IN_W-1:0] mag_hi, mag_lo;
   logic [D_W-1:0]         env;
   logic signed [D_W-1:0]  diff, d_next, s3_d;
   logic                   s3_v, s3_first, s3_last;

   logic signed [ACC_W-1:0] d_ext, acc;
   logic                    s4_dump;
   logic signed [OUT_W-1:0] sat_val;
   logic                    sat_ovf;

   // Block bookkeeping happens at the input so mode/ratio latch against the sample stream.
   always_comb begin
      eff_in    = (dec_ratio == '0) ? ONE : dec_ratio;
      is_first  = (cnt == '0);
      cur_ratio = is_first ? eff_in : ratio_l;
      cur_mode  = is_first ? demod_mode_e'(mode) : mode_l;
      is_last   = (cnt == cur_ratio - ONE);
   end

   always_ff @(posedge clk_data or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         ratio_l   <= '0;
         mode_l    <= MODE_FM;
         hist_i    <= '0;
         hist_q    <= '0;
         primed    <= 1'b0;
         s1_v      <= 1'b0;
         s1_i      <= '0;
         s1_q      <= '0;
         s1_pi     <= '0;
         s1_pq     <= '0;
         s1_primed <= 1'b0;
         s1_mode   <= MODE_FM;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
      end else if (clr) begin
         cnt    <= '0;
         hist_i <= '0;
         hist_q <= '0;
         primed <= 1'b0;
         s1_v   <= 1'b0;
      end else begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_i      <= in_i;
            s1_q      <= in_q;
            s1_pi     <= hist_i;
            s1_pq     <= hist_q;
            s1_primed <= primed;
            s1_mode   <= cur_mode;
            s1_first  <= is_first;
            s1_last   <= is_last;
            hist_i    <= in_i;
            hist_q    <= in_q;
            primed    <= 1'b1;
            cnt       <= is_last ? '0 : cnt + ONE;
            if (is_first) begin
               ratio_l <= eff_in;
               mode_l  <= cur_mode;
            end
         end
      end
   end

   always_comb begin
      prod_a = $signed({{IN_W{s1_pi[IN_W-1]}}, s1_pi}) * $signed({{IN_W{s1_q[IN_W-1]}}, s1_q});
      prod_b = $signed({{IN_W{s1_pq[IN_W-1]}}, s1_pq}) * $signed({{IN_W{s1_i[IN_W-1]}}, s1_i});
      if (!s1_primed) begin
         prod_a = '0;
         prod_b = '0;
      end
   end

   always_ff @(posedge clk_data or negedge rst_n) begin
      if (!rst_n) begin
         s2_v     <= 1'b0;
         s2_p1    <= '0;
         s2_p2    <= '0;
         s2_a     <= '0;
         s2_b     <= '0;
         s2_mode  <= MODE_FM;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
      end else begin
         s2_v     <= s1_v & ~clr;
         s2_p1    <= prod_a;
         s2_p2    <= prod_b;
         s2_a     <= sat_abs(s1_i);
         s2_b     <= sat_abs(s1_q);
         s2_mode  <= s1_mode;
         s2_first <= s1_first;
         s2_last  <= s1_last;
      end
   end

   always_comb begin
      mag_hi = (s2_a > s2_b) ? s2_a : s2_b;
      mag_lo = (s2_a > s2_b) ? s2_b : s2_a;
      env    = {{(IN_W+1){1'b0}}, mag_hi} + {{(IN_W+1){1'b0}}, (mag_lo >>> 1)};
      diff   = {s2_p1[P_W-1], s2_p1} - {s2_p2[P_W-1], s2_p2};
      d_next = (s2_mode == MODE_AM) ? env : diff;
   end

   always_ff @(posedge clk_data or negedge rst_n) begin
      if (!rst_n) begin
         s3_v     <= 1'b0;
         s3_d     <= '0;
         s3_first <= 1'b0;
         s3_last  <= 1'b0;
      end else begin
         s3_v     <= s2_v & ~clr;
         s3_d     <= d_next;
         s3_first <= s2_first;
         s3_last  <= s2_last;
      end
   end

   assign d_ext = {{(ACC_W-D_W){s3_d[D_W-1]}}, s3_d};

   always_ff @(posedge clk_data or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         s4_dump <= 1'b0;
      end else if (clr) begin
         acc     <= '0;
         s4_dump <= 1'b0;
      end else begin
         s4_dump <= s3_v & s3_last;
         if (s3_v) begin
            acc <= s3_first ? d_ext : acc + d_ext;
         end
      end
   end

   fm_discrim_dec_sat_shift #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_sat_shift (
      .acc     (acc),
      .shift   (out_shift),
      .sat_out (sat_val),
      .ovf     (sat_ovf)
   );

   // out_data deliberately survives clr; only the strobe and sticky flag are cleared.
   always_ff @(posedge clk_data or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else if (clr) begin
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= s4_dump;
         if (s4_dump) begin
            out_data <= sat_val;
            if (sat_ovf) begin
               sat_flag <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/fm_discrim_dec.md
# fm_discrim_dec

Parametrised baseband discriminator with programmable decimation for the SDR receive chain. It sits after the I/Q channel low-pass filters and before the audio-rate filtering. It accepts a validated I/Q sample stream and produces either an FM cross-product discriminator or an AM envelope. The result is integrated-and-dumped over a run-time ratio, then scaled, saturated and emitted with a valid strobe. Demod mode, decimation and gain are run-time inputs, not constants.

## Interface
- IN_W, 18: signed width of I/Q samples
- OUT_W, 16: signed output width
- DEC_W, 8: width of decimation ratio port
- derived ACC_W = 2*IN_W+1+DEC_W: accumulator width (constant, not overridable)
- clk_data  in  1  sample-domain clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of pipeline, history and accumulator
- in_valid  in  1  qualifies in_i/in_q
- in_i  in  IN_W  signed in-phase sample
- in_q  in  IN_W  signed quadrature sample
- mode  in  1  0 = FM discriminator, 1 = AM envelope
- dec_ratio  in  DEC_W  samples per output; 0 treated as 1
- out_shift  in  6  arithmetic right shift applied to the accumulator before saturation
- out_data  out  OUT_W  signed result, held between strobes
- out_valid  out  1  one-cycle strobe per output
- sat_flag  out  1  sticky; set when any output saturated, cleared by reset/clr

## Operation
- FM, sample n: d = I[n-1]*Q[n] - Q[n-1]*I[n], full width 2*IN_W+1, no truncation.
- History registers hold the previous sample. The first valid sample after reset/clr gives d = 0 (primed flag), then becomes history.
- AM: a = |I| and b = |Q|, each saturated to 2^(IN_W-1)-1 (most-negative input does not wrap). d = max(a,b) + (min(a,b)>>>1), sign-extended to 2*IN_W+1.
- History updates on every valid sample in both modes. Switching to FM mid-stream needs no re-prime.
- Decimator: the counter counts valid d values. The accumulator loads d on the first sample of a block and adds d on later samples. The block dumps when the count reaches eff_ratio-1, where eff_ratio = max(dec_ratio,1).
- mode and dec_ratio are latched only at a block start (counter = 0). A change mid-block takes effect at the next block.
- Dump: acc >>> out_shift (floor), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Saturation sets sat_flag.
- out_shift is sampled on the dump cycle.
- clr: zeros history, primed flag, counter, accumulator, pipeline valids and sat_flag. out_data holds its value. No out_valid arises from samples accepted before clr.
- Reset: out_data = 0, out_valid = 0, sat_flag = 0, all internal state = 0.

## Timing
- Pipeline is fully registered, one sample per cycle at full rate (in_valid may be high every cycle).
- Stage 1: capture in_i/in_q and history.
- Stage 2: products (FM) or abs values (AM).
- Stage 3: difference / envelope combine (d valid).
- Stage 4: accumulate / dump decision.
- Stage 5: shift+saturate register drives out_data/out_valid.
- Latency: the in_valid of the last sample of a block at cycle k gives out_valid at cycle k+5. The final accumulate includes that sample.
- Gaps in in_valid stall nothing. Each stage's valid bit propagates, and the counter advances only on valid d.
- clr at cycle k drops every in-flight valid. The earliest sample counted after clr is the one presented at k+1.
- Simultaneous clr and in_valid: clr wins and the sample is discarded.
- Output rate equals the input valid rate / eff_ratio exactly, with no dropped or doubled strobes across ratio changes.

## Structure
- Shared package: mode encodings (MODE_FM, MODE_AM), the ACC_W derivation function, and the saturate-to-width function, reused by other demod blocks.
- One natural sub-module: sat_shift. It is the parametrised arithmetic shift and saturation stage (ACC_W in, OUT_W out, overflow flag) and is instantiated once.
- Everything else stays inline, estimated at 200–300 lines.

## Test plan
- FM constant phase: IN_W = 18; repeated (1000,0); dec_ratio = 1, shift 0 -> out_data = 0 on every strobe, first included.
- FM +90° rotation: (1000,0),(0,1000),(-1000,0),(0,-1000) cycling; dec 1, shift 6 -> first strobe 0, then 15625 steady. Reverse rotation -> -15625. Strobe 5 cycles after each input.
- Decimation: same +90° stream; dec_ratio = 4, shift 8. First block gives (0+3e6)/256 = 11718, then 15625. Exactly one strobe per 4 valids, with random in_valid gaps.
- Saturation: +90° stream, dec 1, shift 0 -> 32767 and sat_flag = 1. Reverse rotation -> -32768. sat_flag stays 1 until clr.
- AM: (3000,-4000) -> 5500. (-131072,0) -> 131071>>>shift 3 = 16383. Mode change mid-block applies only at the next block start.
- Reset/clr: assert clr mid-block (dec 4, after 2 samples) -> no strobe from old samples. Next strobe comes after 4 new valids, and its first d is 0 (re-primed). Async rst_n mid-stream zeros out_data, out_valid and sat_flag immediately.
